// File: rtl/main_memory_responder.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | main_memory_responder: block-level main-memory model for cache refill and    |
// | write-back, with programmable access latency. Rev 1.0                        |
// +------------------------------------------------------------------------------+
module main_memory_responder #(
  parameter int BLK_ADDR_W = 14,
  parameter int WORD_W     = 64,
  parameter int BEATS      = 8,
  parameter int LATENCY    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [BLK_ADDR_W-1:0]    req_blk_addr,
  input  logic [$clog2(BEATS)-1:0] req_word,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WORD_W-1:0]        rd_data,
  output logic [$clog2(BEATS)-1:0] rd_word,
  output logic                     rd_last,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WORD_W-1:0]        wr_data,
  output logic                     wr_done,
  output logic                     busy
);

  localparam int                BEAT_W    = $clog2(BEATS);
  localparam int                MEM_AW    = BLK_ADDR_W + BEAT_W;
  localparam int                MEM_DEPTH = 1 << MEM_AW;
  localparam logic [3:0]        LAT_LOAD  = 4'(LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    WR_WAIT  = 3'd4
  } state_t;

  state_t                  state_q,   state_d;
  logic [BLK_ADDR_W-1:0]   blk_q,     blk_d;
  logic [BEAT_W-1:0]       crit_q,    crit_d;
  logic [3:0]              lat_q,     lat_d;
  logic [BEAT_W-1:0]       beat_q,    beat_d;
  logic [BEAT_W-1:0]       word_q,    word_d;
  logic [WORD_W-1:0]       rd_data_q, rd_data_d;
  logic                    wr_done_q, wr_done_d;

  logic [WORD_W-1:0]       mem [0:MEM_DEPTH-1];
  logic [MEM_AW-1:0]       mem_rd_addr;
  logic [WORD_W-1:0]       mem_rd_data;
  logic                    mem_we;

  assign mem_rd_data = mem[mem_rd_addr];

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    crit_d      = crit_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    word_d      = word_q;
    rd_data_d   = rd_data_q;
    wr_done_d   = 1'b0;
    mem_we      = 1'b0;
    mem_rd_addr = {blk_q, word_q + BEAT_ONE};

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          blk_d   = req_blk_addr;
          crit_d  = req_word;
          beat_d  = '0;
          lat_d   = LAT_LOAD;
          state_d = req_write ? WR_BURST : RD_WAIT;
        end
      end

      RD_WAIT: begin
        // Prefetch the critical word so it is on rd_data with the first rd_valid.
        mem_rd_addr = {blk_q, crit_q};
        if (lat_q == 4'd0) begin
          state_d   = RD_BURST;
          word_d    = crit_q;
          rd_data_d = mem_rd_data;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      RD_BURST: begin
        if (rd_ready) begin
          beat_d    = beat_q + BEAT_ONE;
          word_d    = word_q + BEAT_ONE;
          rd_data_d = mem_rd_data;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end

      WR_BURST: begin
        if (wr_valid) begin
          mem_we = 1'b1;
          beat_d = beat_q + BEAT_ONE;
          if (beat_q == LAST_BEAT) begin
            state_d = WR_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end

      WR_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      crit_q    <= '0;
      lat_q     <= '0;
      beat_q    <= '0;
      word_q    <= '0;
      rd_data_q <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      crit_q    <= crit_d;
      lat_q     <= lat_d;
      beat_q    <= beat_d;
      word_q    <= word_d;
      rd_data_q <= rd_data_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Array has no reset; a beat arriving in the same cycle as rst is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[{blk_q, beat_q}] <= wr_data;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rd_valid  = (state_q == RD_BURST);
  assign rd_data   = rd_data_q;
  assign rd_word   = word_q;
  assign rd_last   = (state_q == RD_BURST) && (beat_q == LAST_BEAT);
  assign wr_ready  = (state_q == WR_BURST);
  assign wr_done   = wr_done_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_main_memory_responder: directed bench for main_memory_responder. Rev 1.0  |
// +------------------------------------------------------------------------------+
module tb_main_memory_responder;

  localparam logic [13:0] BLK = 14'h0A5B;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [13:0] req_blk_addr;
  logic [2:0]  req_word;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic [2:0]  rd_word;
  logic        rd_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic        wr_done;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] model [8];

  always #5 clk = ~clk;

  main_memory_responder #(
    .BLK_ADDR_W(14),
    .WORD_W    (64),
    .BEATS     (8),
    .LATENCY   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_blk_addr(req_blk_addr),
    .req_word    (req_word),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_word     (rd_word),
    .rd_last     (rd_last),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_done     (wr_done),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [63:0] base);
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_blk_addr = BLK;
    req_word     = 3'd0;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1;
      wr_data  = base | 64'(k);
      check("wr_ready", {63'd0, wr_ready}, 64'd1);
      tick();
      model[k] = base | 64'(k);
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("wr_done_early", {63'd0, wr_done}, 64'd0);
      tick();
    end
    check("wr_done_pulse", {63'd0, wr_done}, 64'd1);
    check("wr_done_busy", {63'd0, busy}, 64'd0);
    check("wr_done_req_ready", {63'd0, req_ready}, 64'd1);
    tick();
    check("wr_done_one_cycle", {63'd0, wr_done}, 64'd0);
  endtask

  task automatic do_read(input logic [2:0] crit, input bit bp);
    int          transfers;
    int          cyc;
    logic [2:0]  exp_word;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_blk_addr = BLK;
    req_word     = crit;
    rd_ready     = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("rd_latency", {63'd0, rd_valid}, 64'd0);
      tick();
    end
    transfers = 0;
    cyc       = 0;
    while (transfers < 8 && cyc < 40) begin
      exp_word = crit + 3'(transfers);
      check("rd_valid", {63'd0, rd_valid}, 64'd1);
      check("rd_word", {61'd0, rd_word}, {61'd0, exp_word});
      check("rd_data", rd_data, model[exp_word]);
      check("rd_last", {63'd0, rd_last}, {63'd0, transfers == 7});
      rd_ready = !(bp && cyc >= 2 && cyc <= 4);
      if (bp) begin
        req_valid = (cyc >= 1 && cyc <= 5);
        req_write = 1'b1;
        check("req_ready_in_burst", {63'd0, req_ready}, 64'd0);
      end
      tick();
      if (rd_ready) transfers++;
      cyc++;
    end
    req_valid = 1'b0;
    rd_ready  = 1'b1;
    check("rd_transfers", 64'(transfers), 64'd8);
    check("rd_after_valid", {63'd0, rd_valid}, 64'd0);
    check("rd_after_req_ready", {63'd0, req_ready}, 64'd1);
    check("rd_after_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b1;
    req_write    = 1'b0;
    req_blk_addr = BLK;
    req_word     = 3'd0;
    rd_ready     = 1'b1;
    wr_valid     = 1'b0;
    wr_data      = 64'd0;

    // Reset held for two edges while a request is pending.
    @(negedge clk);
    check("rst_req_ready_0", {63'd0, req_ready}, 64'd0);
    check("rst_busy_0", {63'd0, busy}, 64'd0);
    tick();
    check("rst_req_ready_1", {63'd0, req_ready}, 64'd0);
    check("rst_busy_1", {63'd0, busy}, 64'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("post_rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    check("post_rst_wr_done", {63'd0, wr_done}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_rd_data", rd_data, 64'd0);
    check("post_rst_rd_word", {61'd0, rd_word}, 64'd0);
    check("post_rst_rd_last", {63'd0, rd_last}, 64'd0);

    do_write(64'h1000_0000_0000_0000);
    do_read(3'd0, 1'b0);
    do_read(3'd5, 1'b0);
    do_read(3'd3, 1'b1);

    // Write aborted by reset after three committed beats.
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_blk_addr = BLK;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = 64'hFFFF_0000_0000_0000 | 64'(k);
      tick();
      model[k] = 64'hFFFF_0000_0000_0000 | 64'(k);
    end
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 64'hFFFF_0000_0000_0003;
    tick();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_wr_ready", {63'd0, wr_ready}, 64'd0);
    check("abort_req_ready", {63'd0, req_ready}, 64'd0);
    check("abort_wr_done", {63'd0, wr_done}, 64'd0);
    rst      = 1'b0;
    wr_valid = 1'b0;
    tick();
    check("abort_idle_req_ready", {63'd0, req_ready}, 64'd1);
    check("abort_idle_busy", {63'd0, busy}, 64'd0);
    for (int c = 0; c < 6; c++) begin
      check("abort_no_wr_done", {63'd0, wr_done}, 64'd0);
      tick();
    end
    do_read(3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
